// File: rtl/global_constants.sv
// global_constants: defaults and shared types for the nFault line driver.
package global_constants;

    localparam int NFAULT_NUM_FAULTS_DEFAULT  = 8;
    localparam int NFAULT_MIN_ASSERT_DEFAULT  = 4;
    localparam int NFAULT_SYNC_STAGES_DEFAULT = 2;

    typedef enum bit [1:0] {
        S_REL   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRIVE = 2'd2
    } nfault_drv_state_t;

endpackage

// File: rtl/fault_sync_latch.sv
// fault_sync_latch: per-bit synchroniser chain feeding sticky fault status bits.
module fault_sync_latch #(
    parameter int NUM_FAULTS  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FAULTS-1:0] fault_in,
    input  logic                  clear_faults,
    output logic [NUM_FAULTS-1:0] fault_status
);

    logic [NUM_FAULTS-1:0] r_sync [SYNC_STAGES];
    logic [NUM_FAULTS-1:0] r_status;
    logic [NUM_FAULTS-1:0] w_fs;

    assign w_fs         = r_sync[SYNC_STAGES-1];
    assign fault_status = r_status;

    // A live synced source re-sets its bit in the same cycle a clear arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            r_status <= '0;
        end else begin
            r_sync[0] <= fault_in;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_status <= w_fs | (r_status & {NUM_FAULTS{~clear_faults}});
        end
    end

endmodule

// File: rtl/nfault_line_driver.sv
// nfault_line_driver: drives the open-drain nFault pad low with a guaranteed
// minimum width while any unmasked latched fault is present.
module nfault_line_driver
    import global_constants::*;
#(
    parameter int NUM_FAULTS        = NFAULT_NUM_FAULTS_DEFAULT,
    parameter int MIN_ASSERT_CYCLES = NFAULT_MIN_ASSERT_DEFAULT,
    parameter int SYNC_STAGES       = NFAULT_SYNC_STAGES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FAULTS-1:0] fault_in,
    input  logic [NUM_FAULTS-1:0] fault_mask,
    input  logic                  clear_faults,
    input  logic                  set_nFault_z,
    input  logic                  set_nFault_value,
    output logic                  nFault_oe,
    output logic [NUM_FAULTS-1:0] fault_status,
    output logic                  fault_pending
);

    localparam logic [7:0] HOLD_LOAD = 8'(MIN_ASSERT_CYCLES - 1);

    nfault_drv_state_t     r_state, w_state_nx;
    logic [7:0]            r_cnt, w_cnt_nx;
    logic                  r_release_req, w_release_nx;
    logic [NUM_FAULTS-1:0] w_status;

    fault_sync_latch #(
        .NUM_FAULTS  (NUM_FAULTS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_latch (
        .clk          (clk),
        .reset        (reset),
        .fault_in     (fault_in),
        .clear_faults (clear_faults),
        .fault_status (w_status)
    );

    assign fault_status  = w_status;
    assign fault_pending = |(w_status & ~fault_mask);
    assign nFault_oe     = (r_state != S_REL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_REL;
            r_cnt         <= '0;
            r_release_req <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_release_req <= w_release_nx;
        end
    end

    // A release request during the hold window is remembered, never acted on early.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_release_nx = r_release_req;
        unique case (r_state)
            S_REL: begin
                if (set_nFault_value && !set_nFault_z && fault_pending) begin
                    w_state_nx   = S_HOLD;
                    w_cnt_nx     = HOLD_LOAD;
                    w_release_nx = 1'b0;
                end
            end
            S_HOLD: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_nx     = r_cnt - 8'd1;
                    w_release_nx = r_release_req | set_nFault_z;
                end else begin
                    w_state_nx = (r_release_req || set_nFault_z || !fault_pending) ? S_REL : S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (set_nFault_z || !fault_pending) w_state_nx = S_REL;
            end
            default: w_state_nx = S_REL;
        endcase
    end

endmodule

// File: tb/tb_nfault_line_driver.sv
// tb_nfault_line_driver: directed self-checking bench for nfault_line_driver.
module tb_nfault_line_driver;
    import global_constants::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] fault_in = '0;
    logic [7:0] fault_mask = '0;
    logic       clear_faults = 1'b0;
    logic       set_nFault_z = 1'b0;
    logic       set_nFault_value = 1'b0;
    logic       nFault_oe;
    logic [7:0] fault_status;
    logic       fault_pending;
    int         checks = 0;
    int         failures = 0;

    nfault_line_driver #(
        .NUM_FAULTS        (8),
        .MIN_ASSERT_CYCLES (4),
        .SYNC_STAGES       (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .fault_in         (fault_in),
        .fault_mask       (fault_mask),
        .clear_faults     (clear_faults),
        .set_nFault_z     (set_nFault_z),
        .set_nFault_value (set_nFault_value),
        .nFault_oe        (nFault_oe),
        .fault_status     (fault_status),
        .fault_pending    (fault_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #12;
        chk("rst_oe", 32'(nFault_oe), 0);
        chk("rst_status", 32'(fault_status), 0);
        chk("rst_state", 32'(dut.r_state), 32'(S_REL));
        tick();
        reset = 1'b1;
        tick();
        // no faults: a value request must not drive the line
        set_nFault_value = 1'b1;
        tick();
        set_nFault_value = 1'b0;
        chk("idle_oe", 32'(nFault_oe), 0);
        chk("idle_status", 32'(fault_status), 0);
        // fault 0x04 appears three edges after it rises
        fault_in = 8'h04;
        tick();
        tick();
        chk("lat_e2_status", 32'(fault_status), 0);
        tick();
        chk("lat_e3_status", 32'(fault_status), 32'h04);
        chk("lat_pending", 32'(fault_pending), 1);
        set_nFault_value = 1'b1;
        tick();
        set_nFault_value = 1'b0;
        chk("hold_n0_oe", 32'(nFault_oe), 1);
        chk("hold_n0_state", 32'(dut.r_state), 32'(S_HOLD));
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("hold_oe", 32'(nFault_oe), 1);
        end
        tick();
        chk("drive_state", 32'(dut.r_state), 32'(S_DRIVE));
        chk("drive_oe", 32'(nFault_oe), 1);
        set_nFault_z = 1'b1;
        tick();
        set_nFault_z = 1'b0;
        chk("z_release_oe", 32'(nFault_oe), 0);
        chk("z_release_state", 32'(dut.r_state), 32'(S_REL));
        // z during hold is deferred to the end of the minimum width
        set_nFault_value = 1'b1;
        tick();
        set_nFault_value = 1'b0;
        set_nFault_z = 1'b1;
        tick();
        set_nFault_z = 1'b0;
        chk("defer_n1_oe", 32'(nFault_oe), 1);
        tick();
        chk("defer_n2_oe", 32'(nFault_oe), 1);
        tick();
        chk("defer_n3_state", 32'(dut.r_state), 32'(S_HOLD));
        tick();
        chk("defer_n4_oe", 32'(nFault_oe), 0);
        chk("defer_n4_state", 32'(dut.r_state), 32'(S_REL));
        // z and value together in S_REL: z wins
        set_nFault_value = 1'b1;
        set_nFault_z = 1'b1;
        tick();
        set_nFault_value = 1'b0;
        set_nFault_z = 1'b0;
        chk("zv_rel_oe", 32'(nFault_oe), 0);
        // drop source, clear, then masked fault 0x10
        fault_in = 8'h00;
        tick();
        tick();
        tick();
        chk("sticky_status", 32'(fault_status), 32'h04);
        clear_faults = 1'b1;
        tick();
        clear_faults = 1'b0;
        chk("clear_status", 32'(fault_status), 0);
        fault_in = 8'h10;
        fault_mask = 8'h10;
        tick();
        tick();
        tick();
        chk("mask_status", 32'(fault_status), 32'h10);
        chk("mask_pending", 32'(fault_pending), 0);
        set_nFault_value = 1'b1;
        tick();
        set_nFault_value = 1'b0;
        chk("mask_oe", 32'(nFault_oe), 0);
        // clear after source drops: S_DRIVE releases one edge later
        fault_mask = 8'h00;
        set_nFault_value = 1'b1;
        tick();
        set_nFault_value = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("drv2_state", 32'(dut.r_state), 32'(S_DRIVE));
        fault_in = 8'h00;
        tick();
        tick();
        clear_faults = 1'b1;
        tick();
        clear_faults = 1'b0;
        chk("drv2_clr_status", 32'(fault_status), 0);
        chk("drv2_clr_pending", 32'(fault_pending), 0);
        chk("drv2_clr_oe_same", 32'(nFault_oe), 1);
        tick();
        chk("drv2_clr_oe_next", 32'(nFault_oe), 0);
        // clear while source still high: bit survives, line stays driven
        fault_in = 8'h10;
        tick();
        tick();
        tick();
        set_nFault_value = 1'b1;
        tick();
        set_nFault_value = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        clear_faults = 1'b1;
        tick();
        clear_faults = 1'b0;
        chk("live_clr_status", 32'(fault_status), 32'h10);
        tick();
        chk("live_clr_oe", 32'(nFault_oe), 1);
        chk("live_clr_state", 32'(dut.r_state), 32'(S_DRIVE));
        // masking in S_DRIVE releases on the next edge
        fault_mask = 8'h10;
        tick();
        chk("mask_drive_oe", 32'(nFault_oe), 0);
        // masking in S_HOLD still completes the minimum width
        fault_mask = 8'h00;
        set_nFault_value = 1'b1;
        tick();
        set_nFault_value = 1'b0;
        fault_mask = 8'h10;
        tick();
        tick();
        tick();
        chk("mask_hold_n3_oe", 32'(nFault_oe), 1);
        tick();
        chk("mask_hold_n4_oe", 32'(nFault_oe), 0);
        // asynchronous reset mid-hold
        fault_mask = 8'h00;
        set_nFault_value = 1'b1;
        tick();
        set_nFault_value = 1'b0;
        tick();
        chk("pre_rst_oe", 32'(nFault_oe), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_oe", 32'(nFault_oe), 0);
        chk("async_rst_status", 32'(fault_status), 0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_state", 32'(dut.r_state), 32'(S_REL));
        chk("post_rst_oe", 32'(nFault_oe), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nfault_line_driver.md
Name: nfault_line_driver

Overview:
- Downstream consumer of the nFault request FSM; it sits between that FSM and the shared open-drain nFault pad.
- Synchronises raw subsystem fault sources and latches them into sticky status bits.
- On set_nFault_value, drives nFault low if any unmasked fault is latched, holding it for a guaranteed minimum width.
- Releases the line on set_nFault_z or when no unmasked fault remains.

Parameters:
NUM_FAULTS, 8, number of independent fault source inputs
MIN_ASSERT_CYCLES, 4, minimum clk cycles nFault is held low once asserted (legal range 1..255)
SYNC_STAGES, 2, flop depth of the per-bit input synchroniser (legal range 2..3)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
fault_in  input  NUM_FAULTS  raw fault levels, asynchronous to clk, active high
fault_mask  input  NUM_FAULTS  1 = ignore that bit for nFault assertion (still latched in status)
clear_faults  input  1  single-cycle pulse; clears latched fault bits
set_nFault_z  input  1  from request FSM: release the line
set_nFault_value  input  1  from request FSM: evaluate faults and drive the line if required
nFault_oe  output  1  1 = pad drives nFault low; 0 = pad high-Z
fault_status  output  NUM_FAULTS  sticky latched fault bits
fault_pending  output  1  |(fault_status & ~fault_mask)

Behaviour:
- Reset is asynchronous, active low. On reset: state = S_REL, nFault_oe = 0, fault_status = 0, hold counter = 0, synchroniser flops = 0, release_req = 0.
- Synchroniser: each fault_in bit passes through SYNC_STAGES flops, giving the synced level fs[i].
- Sticky latch, each cycle: status[i] <= fs[i] | (status[i] & ~clear_faults).
  - A set takes priority over clear in the same cycle.
  - A bit whose source is still high stays set through clear_faults.
- fault_pending is combinational from registered status and fault_mask.
- Latency: a fault_in rising level appears in fault_status SYNC_STAGES+1 clk edges later.
- FSM has 3 states, with Moore output nFault_oe = (state != S_REL).
  - S_REL: line released.
    - set_nFault_value & fault_pending -> S_HOLD; load counter = MIN_ASSERT_CYCLES-1; clear release_req.
    - Otherwise stay in S_REL.
  - S_HOLD: line driven.
    - Counter decrements each cycle.
    - set_nFault_z during S_HOLD sets release_req; the release is deferred and never shortens the pulse.
    - counter==0 and (release_req | set_nFault_z | ~fault_pending) -> S_REL.
    - counter==0 otherwise -> S_DRIVE.
  - S_DRIVE: line driven.
    - set_nFault_z or ~fault_pending -> S_REL.
    - set_nFault_value -> stay in S_DRIVE; no reload.
- Timing: a set_nFault_value pulse sampled at edge N gives nFault_oe = 1 from edge N until at least edge N+MIN_ASSERT_CYCLES.
- Simultaneous set_nFault_z and set_nFault_value: z wins in every state. In S_REL the line stays released.
- Masking a bit while driven: fault_pending falls, and S_DRIVE releases on the next edge; S_HOLD still completes its minimum width.
- clear_faults while driven behaves identically to masking.
- Reset mid-operation releases the line immediately (asynchronously) and drops all status.
- The unique case must have a default that forces S_REL, as a safe recovery state.

Decomposition:
- Shared package global_constants.sv holds:
  - NFAULT_NUM_FAULTS_DEFAULT and NFAULT_MIN_ASSERT_DEFAULT;
  - the state enum type nfault_drv_state_t {S_REL, S_HOLD, S_DRIVE}, encoded in bit [1:0].
- Sub-module fault_sync_latch (parameters NUM_FAULTS, SYNC_STAGES) holds the synchroniser chain plus sticky latch and clear logic.
- The top level holds the FSM, hold counter and release_req.

Test Plan:
- Reset with fault_in = 8'h00; pulse set_nFault_value -> nFault_oe stays 0, fault_status = 0.
- fault_in = 8'h04, mask = 0, then set_nFault_value pulse at edge N -> fault_status = 8'h04 three edges after fault_in rises; nFault_oe = 1 from N through N+4 (MIN = 4); state S_DRIVE; then set_nFault_z -> nFault_oe = 0 next edge.
- Line asserted, set_nFault_z at hold cycle 1 -> nFault_oe remains 1 for the full 4 cycles, then 0 with no S_DRIVE visit.
- fault_in = 8'h10 with mask = 8'h10, set_nFault_value -> fault_status = 8'h10, fault_pending = 0, nFault_oe stays 0.
- In S_DRIVE, drop fault_in to 0 then pulse clear_faults -> fault_status = 0, nFault_oe = 0 next edge.
  - Repeat with fault_in still high -> status bit survives the clear; line stays driven.
- Assert reset low mid-S_HOLD -> nFault_oe = 0 and fault_status = 0 without waiting for a clk edge; after reset releases, state = S_REL.
